// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the clk_1x reset sequencer.
// Lock-loss counting is enabled with RESET_SEQ_LOCK_LOSS_COUNT_EN.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK   = 2'd0,
    QUALIFY     = 2'd1,
    RELEASE_SYS = 2'd2,
    RUN         = 2'd3
  } seq_state_e;

  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_CPU_DELAY_CYCLES   = 256;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Generic two-flop synchroniser, async active-high reset to zero.
// Used to bring the PLL locked status into clk_1x.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Staged system/CPU reset release from PLL lock for clk_1x.
// Define RESET_SEQ_LOCK_LOSS_COUNT_EN to add the lock_loss_count port.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int CPU_DELAY_CYCLES   = DEF_CPU_DELAY_CYCLES
) (
  input  logic       clk_1x,
  input  logic       reset,
  input  logic       locked,
  input  logic       soft_reset_req,
  output logic       system_reset,
  output logic       cpu_reset,
`ifdef RESET_SEQ_LOCK_LOSS_COUNT_EN
  output logic [7:0] lock_loss_count,
`endif
  output logic       ready
);

  localparam int CNT_MAX = max_int(LOCK_STABLE_CYCLES, CPU_DELAY_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] QUAL_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CPU_LAST  = CW'(CPU_DELAY_CYCLES - 1);

  logic          locked_sync;
  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sys_rst_q, sys_rst_d;
  logic          cpu_rst_q, cpu_rst_d;
  logic          ready_q, ready_d;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk (clk_1x),
    .rst (reset),
    .d   (locked),
    .q   (locked_sync)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_sync) state_d = QUALIFY;
      end
      QUALIFY: begin
        if (!locked_sync) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == QUAL_LAST) begin
          state_d = RELEASE_SYS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE_SYS: begin
        // Lock loss outranks a coincident soft request.
        if (!locked_sync) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (soft_reset_req) begin
          state_d = QUALIFY;
          cnt_d   = '0;
        end else if (cnt_q == CPU_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!locked_sync) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (soft_reset_req) begin
          state_d = QUALIFY;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_comb begin
    sys_rst_d = !(state_d == RELEASE_SYS || state_d == RUN);
    cpu_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
  end

  always_ff @(posedge clk_1x or posedge reset) begin
    if (reset) begin
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      sys_rst_q <= 1'b1;
      cpu_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sys_rst_q <= sys_rst_d;
      cpu_rst_q <= cpu_rst_d;
      ready_q   <= ready_d;
    end
  end

  assign system_reset = sys_rst_q;
  assign cpu_reset    = cpu_rst_q;
  assign ready        = ready_q;

`ifdef RESET_SEQ_LOCK_LOSS_COUNT_EN
  logic       lost;
  logic [7:0] llc_q, llc_d;

  always_comb begin
    lost  = !locked_sync && (state_q == RELEASE_SYS || state_q == RUN);
    llc_d = llc_q;
    if (lost && llc_q != 8'hFF) llc_d = llc_q + 8'd1;
  end

  always_ff @(posedge clk_1x or posedge reset) begin
    if (reset) llc_q <= '0;
    else       llc_q <= llc_d;
  end

  assign lock_loss_count = llc_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed checks of reset_sequencer with short qualify/CPU delays.
// Counter checks apply when RESET_SEQ_LOCK_LOSS_COUNT_EN is defined.
module tb_reset_sequencer;

  localparam int L = 16;
  localparam int D = 8;

  logic       clk_1x = 1'b0;
  logic       reset;
  logic       locked;
  logic       soft_reset_req;
  logic       system_reset;
  logic       cpu_reset;
  logic       ready;
  logic [7:0] llc;

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;

  always #5 clk_1x = ~clk_1x;

  reset_sequencer #(
    .LOCK_STABLE_CYCLES (L),
    .CPU_DELAY_CYCLES   (D)
  ) dut (
    .clk_1x          (clk_1x),
    .reset           (reset),
    .locked          (locked),
    .soft_reset_req  (soft_reset_req),
    .system_reset    (system_reset),
    .cpu_reset       (cpu_reset),
`ifdef RESET_SEQ_LOCK_LOSS_COUNT_EN
    .lock_loss_count (llc),
`endif
    .ready           (ready)
  );

`ifndef RESET_SEQ_LOCK_LOSS_COUNT_EN
  assign llc = 8'd0;
`endif

  typedef struct packed {
    int         e;
    logic       lk;
    logic       sf;
    logic       sys;
    logic       cpu;
    logic       rdy;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int e, logic lk, logic sf,
                              logic sys, logic cpu, logic rdy,
                              logic [7:0] cnt);
    vec_t v;
    v.e = e; v.lk = lk; v.sf = sf;
    v.sys = sys; v.cpu = cpu; v.rdy = rdy; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk_out(string nm, logic [2:0] exp3);
    logic [2:0] got;
    got = {system_reset, cpu_reset, ready};
    total++;
    if (got !== exp3) begin
      bad++;
      $display("FAIL %s: got sys/cpu/rdy=%b want %b", nm, got, exp3);
    end
  endtask

  task automatic chk_llc(string nm, logic [7:0] exp8);
`ifdef RESET_SEQ_LOCK_LOSS_COUNT_EN
    total++;
    if (llc !== exp8) begin
      bad++;
      $display("FAIL %s: got lock_loss_count=%0d want %0d", nm, llc, exp8);
    end
`else
    if (exp8 === 8'hxx) $display("unused %s", nm);
`endif
  endtask

  task automatic goto(int target);
    while (ecnt < target) begin
      @(posedge clk_1x);
      ecnt++;
    end
    #1;
  endtask

  task automatic wait_sys(logic lvl, string nm);
    int n;
    n = 0;
    while (system_reset !== lvl && n < 100) begin
      @(posedge clk_1x);
      #1;
      n++;
    end
    if (system_reset !== lvl) begin
      total++;
      bad++;
      $display("FAIL %s: timeout, system_reset=%b want %b", nm, system_reset, lvl);
    end
  endtask

  initial begin
    reset = 1'b1;
    locked = 1'b0;
    soft_reset_req = 1'b0;

    // edge e: check right after edge e, then drive lk/sf
    tbl.push_back(mk(  0, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(  2, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(  3, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk( 18, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk( 19, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk( 26, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk( 27, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(100, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(101, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(116, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(117, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(124, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(125, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(130, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(132, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(133, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(140, 1, 0, 1, 1, 0, 1));
    tbl.push_back(mk(153, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(157, 1, 0, 1, 1, 0, 1));
    tbl.push_back(mk(159, 1, 0, 1, 1, 0, 1));
    tbl.push_back(mk(175, 1, 0, 1, 1, 0, 1));
    tbl.push_back(mk(176, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(183, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(184, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(190, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(192, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(193, 1, 0, 1, 1, 0, 2));
    tbl.push_back(mk(211, 1, 0, 1, 1, 0, 2));
    tbl.push_back(mk(212, 1, 0, 0, 1, 0, 2));
    tbl.push_back(mk(220, 1, 0, 0, 0, 1, 2));

    #2;
    chk_out("por_reset", 3'b110);
    chk_llc("por_llc", 8'd0);
    #10;
    reset = 1'b0;
    @(posedge clk_1x);
    ecnt = 0;

    foreach (tbl[i]) begin
      goto(tbl[i].e);
      chk_out($sformatf("edge%0d", tbl[i].e),
              {tbl[i].sys, tbl[i].cpu, tbl[i].rdy});
      chk_llc($sformatf("edge%0d_llc", tbl[i].e), tbl[i].cnt);
      locked = tbl[i].lk;
      soft_reset_req = tbl[i].sf;
    end

    // async reset mid-RUN, between edges
    #2;
    reset = 1'b1;
    #1;
    chk_out("async_reset", 3'b110);
    chk_llc("async_llc", 8'd0);
    @(negedge clk_1x);
    reset = 1'b0;
    ecnt = 0;
    goto(18);
    chk_out("post_rst_e18", 3'b110);
    goto(19);
    chk_out("post_rst_e19", 3'b010);
    goto(26);
    chk_out("post_rst_e26", 3'b010);
    goto(27);
    chk_out("post_rst_e27", 3'b001);

`ifdef RESET_SEQ_LOCK_LOSS_COUNT_EN
    for (int k = 0; k < 300; k++) begin
      locked = 1'b1;
      wait_sys(1'b0, "sat_release");
      locked = 1'b0;
      wait_sys(1'b1, "sat_loss");
    end
    chk_llc("saturate", 8'd255);
    locked = 1'b1;
    wait_sys(1'b0, "sat_relock");
    repeat (D + 2) @(posedge clk_1x);
    #1;
    chk_out("sat_run", 3'b001);
    soft_reset_req = 1'b1;
    @(posedge clk_1x);
    #1;
    soft_reset_req = 1'b0;
    chk_out("sat_soft", 3'b110);
    chk_llc("soft_keeps_llc", 8'd255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
